// File: rtl/reg_file_cfg.sv
// rtl/reg_file_cfg.sv - parametrised register file with registered read, error strobe and config lock
// Registers 0..3 are exported continuously; writing bit 0 of register DEPTH-1 locks them until reset.
module reg_file_cfg #(
    parameter int             WIDTH        = 8,
    parameter int             DEPTH        = 16,
    parameter int             ADDR         = 4,
    parameter logic [7:0]     UART_CFG_RST = 8'b1000_0001,
    parameter logic [7:0]     DIV_RST      = 8'd32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [ADDR-1:0]   Address,
    input  logic [WIDTH-1:0]  WrData,
    output logic [WIDTH-1:0]  RdData,
    output logic              RdData_Valid,
    output logic              Err,
    output logic              Locked,
    output logic [WIDTH-1:0]  REG0,
    output logic [WIDTH-1:0]  REG1,
    output logic [WIDTH-1:0]  REG2,
    output logic [WIDTH-1:0]  REG3
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_err;
    logic             r_locked;

    logic             w_in_range;
    logic             w_cfg_addr;
    logic             w_wr_req;
    logic             w_rd_req;
    logic             w_conflict;
    logic             w_wr_ok;
    logic             w_err_next;

    assign w_in_range = ({1'b0, Address} < (ADDR+1)'(DEPTH));
    assign w_cfg_addr = (Address <= ADDR'(3));
    assign w_wr_req   = WrEn & ~RdEn;
    assign w_rd_req   = RdEn & ~WrEn;
    assign w_conflict = WrEn & RdEn;
    // Lock gates only the exported configuration registers; the lock register stays writable.
    assign w_wr_ok    = w_wr_req & w_in_range & ~(r_locked & w_cfg_addr);
    assign w_err_next = w_conflict | (w_wr_req & ~w_wr_ok) | (w_rd_req & ~w_in_range);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_mem[2]   <= WIDTH'(UART_CFG_RST);
            r_mem[3]   <= WIDTH'(DIV_RST);
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_req;
            r_err      <= w_err_next;
            if (w_wr_ok) begin
                r_mem[Address] <= WrData;
                if ((Address == ADDR'(DEPTH-1)) && WrData[0]) begin
                    r_locked <= 1'b1;
                end
            end
            if (w_rd_req) begin
                r_rd_data <= w_in_range ? r_mem[Address] : '0;
            end
        end
    end

    assign RdData       = r_rd_data;
    assign RdData_Valid = r_rd_valid;
    assign Err          = r_err;
    assign Locked       = r_locked;
    assign REG0         = r_mem[0];
    assign REG1         = r_mem[1];
    assign REG2         = r_mem[2];
    assign REG3         = r_mem[3];

endmodule

// File: tb/tb_reg_file_cfg.sv
// tb/tb_reg_file_cfg.sv - directed self-checking bench for reg_file_cfg (DEPTH=16 and DEPTH=12)
module tb_reg_file_cfg;

    logic       clk = 1'b0;
    logic       rst;

    logic       we_a, re_a;
    logic [3:0] addr_a;
    logic [7:0] wd_a;
    logic [7:0] rd_a, r0_a, r1_a, r2_a, r3_a;
    logic       vld_a, err_a, lck_a;

    logic       we_b, re_b;
    logic [3:0] addr_b;
    logic [7:0] wd_b;
    logic [7:0] rd_b, r0_b, r1_b, r2_b, r3_b;
    logic       vld_b, err_b, lck_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_cfg #(.WIDTH(8), .DEPTH(16), .ADDR(4)) u_a (
        .clk(clk), .rst(rst), .WrEn(we_a), .RdEn(re_a), .Address(addr_a), .WrData(wd_a),
        .RdData(rd_a), .RdData_Valid(vld_a), .Err(err_a), .Locked(lck_a),
        .REG0(r0_a), .REG1(r1_a), .REG2(r2_a), .REG3(r3_a)
    );

    reg_file_cfg #(.WIDTH(8), .DEPTH(12), .ADDR(4)) u_b (
        .clk(clk), .rst(rst), .WrEn(we_b), .RdEn(re_b), .Address(addr_b), .WrData(wd_b),
        .RdData(rd_b), .RdData_Valid(vld_b), .Err(err_b), .Locked(lck_b),
        .REG0(r0_b), .REG1(r1_b), .REG2(r2_b), .REG3(r3_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
        we_a = we; re_a = re; addr_a = a; wd_a = d;
        @(posedge clk); #1;
        we_a = 1'b0; re_a = 1'b0;
    endtask

    task automatic step_b(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
        we_b = we; re_b = re; addr_b = a; wd_b = d;
        @(posedge clk); #1;
        we_b = 1'b0; re_b = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        we_a = 0; re_a = 0; addr_a = 0; wd_a = 0;
        we_b = 0; re_b = 0; addr_b = 0; wd_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_reg0", r0_a, 8'h00);
        chk("rst_reg1", r1_a, 8'h00);
        chk("rst_reg2", r2_a, 8'h81);
        chk("rst_reg3", r3_a, 8'h20);
        chk("rst_rddata", rd_a, 8'h00);
        chk("rst_locked", lck_a, 1'b0);
        chk("rst_valid", vld_a, 1'b0);
        chk("rst_err", err_a, 1'b0);
        rst = 1'b1;

        step_a(1, 0, 4'd3, 8'h0B);
        chk("wr3_reg3", r3_a, 8'h0B);
        chk("wr3_err", err_a, 1'b0);
        chk("wr3_valid", vld_a, 1'b0);
        step_a(1, 0, 4'd7, 8'h01);
        step_a(1, 0, 4'd1, 8'h1C);
        chk("wr1_reg1", r1_a, 8'h1C);

        step_a(0, 1, 4'd3, 8'h00);
        chk("rd3_data", rd_a, 8'h0B);
        chk("rd3_valid", vld_a, 1'b1);
        chk("rd3_err", err_a, 1'b0);
        step_a(0, 1, 4'd1, 8'h00);
        chk("rd1_data", rd_a, 8'h1C);
        chk("rd1_valid", vld_a, 1'b1);
        step_a(0, 1, 4'd7, 8'h00);
        chk("rd7_data", rd_a, 8'h01);
        step_a(0, 0, 4'd0, 8'h00);
        chk("idle_valid", vld_a, 1'b0);
        chk("idle_hold", rd_a, 8'h01);

        step_a(1, 1, 4'd5, 8'hAA);
        chk("conf_err", err_a, 1'b1);
        chk("conf_valid", vld_a, 1'b0);
        chk("conf_hold", rd_a, 8'h01);
        step_a(0, 1, 4'd5, 8'h00);
        chk("conf_rd5", rd_a, 8'h00);
        chk("conf_rd5_err", err_a, 1'b0);

        step_a(1, 0, 4'd15, 8'h01);
        chk("lock_set", lck_a, 1'b1);
        chk("lock_wr_err", err_a, 1'b0);
        step_a(1, 0, 4'd0, 8'h55);
        chk("lock_wr0_err", err_a, 1'b1);
        chk("lock_reg0", r0_a, 8'h00);
        step_a(1, 0, 4'd4, 8'h66);
        chk("lock_wr4_err", err_a, 1'b0);
        step_a(0, 1, 4'd4, 8'h00);
        chk("lock_rd4", rd_a, 8'h66);
        step_a(0, 1, 4'd0, 8'h00);
        chk("lock_rd0", rd_a, 8'h00);
        chk("lock_rd0_valid", vld_a, 1'b1);
        step_a(1, 0, 4'd15, 8'h00);
        chk("lock_sticky", lck_a, 1'b1);

        step_b(0, 1, 4'd2, 8'h00);
        chk("b_rd2", rd_b, 8'h81);
        step_b(1, 0, 4'd13, 8'h33);
        chk("b_oor_wr_err", err_b, 1'b1);
        chk("b_oor_wr_valid", vld_b, 1'b0);
        chk("b_oor_reg0", r0_b, 8'h00);
        chk("b_oor_reg3", r3_b, 8'h20);
        chk("b_oor_lock", lck_b, 1'b0);
        step_b(0, 1, 4'd13, 8'h00);
        chk("b_oor_rd_data", rd_b, 8'h00);
        chk("b_oor_rd_valid", vld_b, 1'b1);
        chk("b_oor_rd_err", err_b, 1'b1);
        step_b(1, 0, 4'd11, 8'h01);
        chk("b_lock_set", lck_b, 1'b1);
        step_b(1, 0, 4'd3, 8'h44);
        chk("b_lock_err", err_b, 1'b1);
        chk("b_lock_reg3", r3_b, 8'h20);

        rst = 1'b0;
        step_a(1, 0, 4'd2, 8'h77);
        chk("mid_rst_reg2", r2_a, 8'h81);
        chk("mid_rst_locked", lck_a, 1'b0);
        chk("mid_rst_err", err_a, 1'b0);
        chk("mid_rst_reg1", r1_a, 8'h00);
        chk("mid_rst_b_locked", lck_b, 1'b0);
        rst = 1'b1;
        step_a(1, 0, 4'd2, 8'h77);
        chk("post_rst_wr2", r2_a, 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
